// File: rtl/pc_next_unit.sv
// pc_next_unit: registered next-PC selector with a small exception sequencer.
//   Picks one of NUM_SRC flattened candidates and loads it into the PC under
//   pc_write / (pc_write_cond & cond). An accepted exc_req saves the PC into
//   EPC and then loads EXC_VECTOR.
// Optional feature macro: PC_ALIGN_CHECK_EN (adds align_err, blocks loads of
//   targets whose low two bits are not zero).
// Ports:
//   clk, reset        rising-edge clock, synchronous active-high reset
//   sel, data_in      candidate index, flattened candidate vector
//   pc_write          unconditional load request
//   pc_write_cond     conditional load request, qualified by cond
//   exc_req           exception request, honoured only in IDLE
//   pc_out, epc_out   registered PC and saved PC
//   busy              exception sequence in progress
//   sel_err           one-cycle pulse after a load with an out-of-range sel
//   align_err         (PC_ALIGN_CHECK_EN only) one-cycle misaligned-load pulse
module pc_next_unit #(
  parameter int unsigned      WIDTH      = 32,
  parameter int unsigned      NUM_SRC    = 6,
  parameter int unsigned      SEL_W      = 3,
  parameter logic [WIDTH-1:0] RESET_PC   = '0,
  parameter logic [WIDTH-1:0] EXC_VECTOR = WIDTH'(32'h0000_00FF)
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [SEL_W-1:0]       sel,
  input  logic [NUM_SRC*WIDTH-1:0] data_in,
  input  logic                   pc_write,
  input  logic                   pc_write_cond,
  input  logic                   cond,
  input  logic                   exc_req,
  output logic [WIDTH-1:0]       pc_out,
  output logic [WIDTH-1:0]       epc_out,
  output logic                   busy,
  output logic                   sel_err
`ifdef PC_ALIGN_CHECK_EN
  ,
  output logic                   align_err
`endif
);

  localparam logic [1:0] ST_IDLE     = 2'd0;
  localparam logic [1:0] ST_EXC_SAVE = 2'd1;
  localparam logic [1:0] ST_EXC_LOAD = 2'd2;

  logic [1:0]       r_state;
  logic [1:0]       w_state_nxt;
  logic [WIDTH-1:0] r_pc;
  logic [WIDTH-1:0] w_pc_nxt;
  logic [WIDTH-1:0] r_epc;
  logic [WIDTH-1:0] w_epc_nxt;
  logic             r_busy;
  logic             r_sel_err;
  logic             w_sel_err_nxt;
  logic [WIDTH-1:0] w_cand;
  logic             w_sel_ok;
  logic             w_load_en;
`ifdef PC_ALIGN_CHECK_EN
  logic             r_align_err;
  logic             w_align_err_nxt;
`endif

  // Candidate mux; unused selector codes yield zero rather than X.
  always_comb begin
    w_cand = '0;
    for (int unsigned i = 0; i < NUM_SRC; i++) begin
      if (sel == SEL_W'(i)) w_cand = data_in[i*WIDTH +: WIDTH];
    end
  end

  assign w_sel_ok  = (32'(sel) < NUM_SRC);
  assign w_load_en = pc_write | (pc_write_cond & cond);

  // Next-state and next-register values.
  always_comb begin
    w_state_nxt   = r_state;
    w_pc_nxt      = r_pc;
    w_epc_nxt     = r_epc;
    w_sel_err_nxt = 1'b0;
`ifdef PC_ALIGN_CHECK_EN
    w_align_err_nxt = 1'b0;
`endif
    case (r_state)
      ST_IDLE: begin
        // Exception wins over any same-cycle load request.
        if (exc_req) begin
          w_state_nxt = ST_EXC_SAVE;
        end else if (w_load_en) begin
          if (!w_sel_ok) begin
            w_sel_err_nxt = 1'b1;
`ifdef PC_ALIGN_CHECK_EN
          end else if (w_cand[1:0] != 2'b00) begin
            w_align_err_nxt = 1'b1;
`endif
          end else begin
            w_pc_nxt = w_cand;
          end
        end
      end
      ST_EXC_SAVE: begin
        w_epc_nxt   = r_pc;
        w_state_nxt = ST_EXC_LOAD;
      end
      ST_EXC_LOAD: begin
        w_pc_nxt    = EXC_VECTOR;
        w_state_nxt = ST_IDLE;
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  // State and output registers; busy is registered from the next state so it
  // matches a decode of the state register.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state   <= ST_IDLE;
      r_pc      <= RESET_PC;
      r_epc     <= '0;
      r_busy    <= 1'b0;
      r_sel_err <= 1'b0;
`ifdef PC_ALIGN_CHECK_EN
      r_align_err <= 1'b0;
`endif
    end else begin
      r_state   <= w_state_nxt;
      r_pc      <= w_pc_nxt;
      r_epc     <= w_epc_nxt;
      r_busy    <= (w_state_nxt != ST_IDLE);
      r_sel_err <= w_sel_err_nxt;
`ifdef PC_ALIGN_CHECK_EN
      r_align_err <= w_align_err_nxt;
`endif
    end
  end

  assign pc_out  = r_pc;
  assign epc_out = r_epc;
  assign busy    = r_busy;
  assign sel_err = r_sel_err;
`ifdef PC_ALIGN_CHECK_EN
  assign align_err = r_align_err;
`endif

endmodule
